// File: rtl/cpu_opponent_input.sv
// cpu_opponent_input
//   Computer-controlled opponent driving the P2 gameplay controller inputs
//   in place of the board buttons. Runs on the 60 Hz frame clock and makes
//   at most one decision per decision tick.
//   P2 stands right of P1, so "toward" is in_left and "away" is in_right.
//
// Ports
//   clk_60Hz      frame clock
//   reset_n       synchronous reset, active low
//   enable        AI active; when low the FSM parks in AI_WAIT, outputs 0
//   opp_pos_x     P1 x position
//   opp_state     P1 controller state code
//   self_pos_x    P2 x position
//   self_state    P2 controller state code
//   self_stunmode P2 stun mode (01 hit, 10 block, 00 none)
//   in_left       move toward the opponent
//   in_right      move away from the opponent
//   attack        attack button
//   ai_state      current AI state (debug / LEDs)
module cpu_opponent_input #(
  parameter int PLAYER_WIDTH    = 64,
  parameter int ATTACK_RANGE    = 40,
  parameter int DECIDE_PERIOD   = 8,
  parameter int APPROACH_MAX    = 60,
  parameter int RETREAT_FRAMES  = 12,
  parameter int ATTACK_HOLD_MAX = 4,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic       clk_60Hz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [9:0] opp_pos_x,
  input  logic [3:0] opp_state,
  input  logic [9:0] self_pos_x,
  input  logic [3:0] self_state,
  input  logic [1:0] self_stunmode,
  output logic       in_left,
  output logic       in_right,
  output logic       attack,
  output logic [2:0] ai_state
);

  typedef enum logic [2:0] {
    AI_WAIT     = 3'd0,
    AI_APPROACH = 3'd1,
    AI_RETREAT  = 3'd2,
    AI_ATTACK   = 3'd3,
    AI_COOLDOWN = 3'd4
  } ai_state_t;

  localparam int DW = (DECIDE_PERIOD > 1) ? $clog2(DECIDE_PERIOD) : 1;
  localparam logic [DW-1:0] DECIDE_LAST = DW'(DECIDE_PERIOD - 1);
  localparam logic [5:0] APPROACH_LAST = 6'(APPROACH_MAX - 1);
  localparam logic [5:0] RETREAT_LAST  = 6'(RETREAT_FRAMES - 1);
  localparam logic [5:0] HOLD_LAST     = 6'(ATTACK_HOLD_MAX - 1);
  localparam logic [5:0] COOL_LAST     = 6'(COOLDOWN_FRAMES - 1);

  ai_state_t     r_state, w_state_nxt;
  logic [DW-1:0] r_decide, w_decide_nxt;
  logic [5:0]    r_timer, w_timer_nxt;
  logic          r_dir, w_dir_nxt;
  logic [7:0]    r_lfsr;
  logic          r_in_left, r_in_right, r_attack;

  // Gap is evaluated one bit wider than the 11-bit result so that a far-left
  // P2 cannot wrap around into a large positive gap; negative saturates to 0.
  logic [11:0] w_gap_full;
  logic [10:0] w_gap;
  logic        w_in_range, w_stun, w_threat, w_override;

  assign w_gap_full = {2'b00, self_pos_x} - {2'b00, opp_pos_x} - 12'(PLAYER_WIDTH);
  assign w_gap      = w_gap_full[11] ? 11'd0 : w_gap_full[10:0];
  assign w_in_range = (w_gap <= 11'(ATTACK_RANGE));
  assign w_stun     = (self_stunmode != 2'b00) || (self_state == 4'd9) || (self_state == 4'd10);
  assign w_threat   = (opp_state == 4'd3) || (opp_state == 4'd6);
  assign w_override = !enable || w_stun;

  always_comb begin
    w_state_nxt  = r_state;
    w_decide_nxt = r_decide;
    w_timer_nxt  = r_timer + 6'd1;
    w_dir_nxt    = r_dir;
    if (w_override) begin
      w_state_nxt  = AI_WAIT;
      w_decide_nxt = '0;
      w_timer_nxt  = '0;
    end else begin
      case (r_state)
        AI_WAIT: begin
          w_timer_nxt = '0;
          if (r_decide == DECIDE_LAST) begin
            w_decide_nxt = '0;
            if (w_threat && w_in_range) begin
              w_state_nxt = AI_RETREAT;
            end else if (w_in_range) begin
              w_state_nxt = AI_ATTACK;
              w_dir_nxt   = r_lfsr[0];
            end else begin
              w_state_nxt = AI_APPROACH;
            end
          end else begin
            w_decide_nxt = r_decide + 1'b1;
          end
        end
        AI_APPROACH: begin
          if (w_in_range) begin
            // Arrived: make the very next cycle a decision tick.
            w_state_nxt  = AI_WAIT;
            w_decide_nxt = DECIDE_LAST;
          end else if (r_timer == APPROACH_LAST) begin
            w_state_nxt = AI_WAIT;
          end
        end
        AI_RETREAT: begin
          // Opponent back to neutral aborts before the timeout.
          if (opp_state <= 4'd2)           w_state_nxt = AI_WAIT;
          else if (r_timer == RETREAT_LAST) w_state_nxt = AI_WAIT;
        end
        AI_ATTACK: begin
          if (self_state == 4'd3 || self_state == 4'd6) w_state_nxt = AI_COOLDOWN;
          else if (r_timer == HOLD_LAST)                w_state_nxt = AI_WAIT;
        end
        AI_COOLDOWN: begin
          // Only idle frames of our own controller count toward cooldown.
          if (self_state != 4'd0)        w_timer_nxt = '0;
          else if (r_timer == COOL_LAST) w_state_nxt = AI_WAIT;
        end
        default: w_state_nxt = AI_WAIT;
      endcase
      if (w_state_nxt != r_state) w_timer_nxt = '0;
    end
  end

  always_ff @(posedge clk_60Hz) begin
    if (!reset_n) begin
      r_state  <= AI_WAIT;
      r_decide <= '0;
      r_timer  <= '0;
      r_dir    <= 1'b0;
      r_lfsr   <= 8'hA5;
    end else begin
      r_state  <= w_state_nxt;
      r_decide <= w_decide_nxt;
      r_timer  <= w_timer_nxt;
      r_dir    <= w_dir_nxt;
      if (enable) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // Outputs decode the registered state one frame later; overrides clear
  // them on the same edge the FSM is forced back to AI_WAIT.
  always_ff @(posedge clk_60Hz) begin
    if (!reset_n || w_override) begin
      r_in_left  <= 1'b0;
      r_in_right <= 1'b0;
      r_attack   <= 1'b0;
    end else begin
      r_in_left  <= (r_state == AI_APPROACH) || ((r_state == AI_ATTACK) && r_dir);
      r_in_right <= (r_state == AI_RETREAT);
      r_attack   <= (r_state == AI_ATTACK);
    end
  end

  assign in_left  = r_in_left;
  assign in_right = r_in_right;
  assign attack   = r_attack;
  assign ai_state = r_state;

endmodule
